iu_div_seq: RTL
===============

Name: iu_div_seq

Overview:
- Parametrised sequential integer divider for the integer pipeline.
- Implements the c_UDIV/c_SDIV modes of the mul/shf/div unit with SPARC V8 semantics: a 2*DW-bit dividend {Y, op1} is divided by a DW-bit op2.
- Sits beside the combinational ALU DSP path. Each operation carries a thread tag, so results can be matched back to the issuing thread.
- Generalises the fixed 32-bit divide to configurable width and radix (bits retired per cycle), and adds a valid/ready handshake and a kill input.

Parameters:
- DW, 32, operand/result width; must be even, >= 8.
- BPC, 1, quotient bits retired per cycle; 1 or 2; DW % BPC == 0.
- TIDW, 6, thread id width (NTHREADIDMSB+1).

Ports:
- clk  in  1  base clock (iu clock domain)
- rstn  in  1  synchronous reset, active-low
- in_valid  in  1  request valid
- in_ready  out  1  unit idle, can accept
- in_tid  in  TIDW  issuing thread id
- in_signed  in  1  1 = SDIV, 0 = UDIV
- in_y  in  DW  Y register (dividend high word)
- in_op1  in  DW  dividend low word
- in_op2  in  DW  divisor
- kill  in  1  abort in-flight op (thread replay/trap)
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- out_tid  out  TIDW  tid of result
- out_result  out  DW  quotient (saturated on overflow)
- out_flag  out  4  {N,Z,V,C} per alu_flag_type
- out_divz  out  1  divide-by-zero; result/flags not meaningful

Behaviour:
- Reset (rstn=0 at clk edge): state IDLE; in_ready=1, out_valid=0, out_result=0, out_flag=0, out_divz=0, out_tid=0.
- States: IDLE, RUN, DONE.
- IDLE:
  - Accept when in_valid & in_ready; capture tid, sign mode, operands.
  - op2==0: go directly to DONE with out_divz=1, out_result=0, out_flag=0. Latency 1 cycle.
  - Otherwise form magnitudes and go to RUN:
    - Signed: |{Y,op1}| as a 2*DW-bit two's complement value, |op2|; record result sign = dividend sign XOR divisor sign.
    - Unsigned: raw values.
  - Pre-overflow check: magnitude high word >= divisor magnitude sets the ovf flag; iterations still run but the result is replaced.
- RUN:
  - Restoring division, BPC quotient bits per cycle, DW/BPC cycles.
  - Iteration counter counts down from DW/BPC-1 and exits to DONE when it reaches 0.
- DONE:
  - Post-processing:
    - Unsigned: ovf -> result all-ones, V=1.
    - Signed, positive sign: ovf or q[DW-1]=1 -> 0111..1, V=1.
    - Signed, negative sign: ovf or q > 2^(DW-1) -> 100..0, V=1. Otherwise -q.
  - Flags: N=result[DW-1], Z=(result==0), V as above, C=0.
  - out_valid=1. Outputs are held stable until out_ready=1, then return to IDLE.
  - Back-to-back: in_ready=1 only in IDLE; no accept during the DONE/out_ready cycle.
- Latency accept -> out_valid: DW/BPC+1 cycles for non-zero divisor (33 for DW=32, BPC=1); 1 cycle for divz.
- kill:
  - In RUN or DONE: return to IDLE next cycle; out_valid drops; no result is emitted.
  - In IDLE with in_valid: kill has priority; the request is not accepted.
- Remainder is discarded. The Y register is not written by this unit.
- rstn low mid-operation: immediate abort to the reset state, same as reset.

Optional Feature:
- Macro: IU_DIV_FASTZERO_EN.
- Defined: in IDLE, if the dividend magnitude is less than the divisor magnitude (high word 0 and low word < divisor, unsigned compare on magnitudes), skip RUN.
  - Go to DONE next cycle with result 0, Z=1, N=V=C=0.
  - Latency 1 cycle.
- Undefined: all non-zero-divisor ops take the full DW/BPC+1 cycles. Results are bit-identical either way; only latency differs.

Decomposition:
- Package libiu:
  - div_state_type enum {IDLE, RUN, DONE}.
  - div_in_type struct (tid, signed, y, op1, op2).
  - div_out_type struct (tid, result, alu_flag_type flag, divz).
  - Reuses the existing alu_flag_type and mul_ctrl_type (c_UDIV/c_SDIV map to in_signed).
- One natural sub-module: iu_div_step. It is a combinational BPC-bit restoring step taking {partial remainder, dividend bits, divisor} and returning {new remainder, quotient bits}, instantiated once.

Test Plan:
- UDIV, y=0, op1=100, op2=7 -> result 14, flag=0000, latency 33 cycles (DW=32, BPC=1).
- UDIV, y=1, op1=0, op2=1 -> ovf, result 0xFFFFFFFF, flag N=1,V=1 (1010).
- SDIV, {y,op1}=-100 (y=0xFFFFFFFF, op1=0xFFFFFF9C), op2=7 -> result 0xFFFFFFF2 (-14), N=1.
- SDIV, y=0, op1=0x80000000, op2=1 -> positive overflow, result 0x7FFFFFFF, V=1. With y=0xFFFFFFFF, op1=0x80000000, op2=1 -> 0x80000000, N=1, V=0.
- op2=0 -> out_divz=1 after 1 cycle. Also assert kill at RUN cycle 10, then re-issue 100/7 with tid=5 -> no stale output; result 14 with out_tid=5.
- Hold out_ready=0 for 5 cycles in DONE -> outputs stable, in_ready=0. Also with IU_DIV_FASTZERO_EN defined: 3/7 -> result 0, Z=1, latency 1 cycle.

Source files
------------

// File: rtl/libiu.sv
// Shared integer-unit types: ALU flags, mul/shf/div control, divider state and request/result bundles.
package libiu;

    localparam int unsigned DivDw   = 32;
    localparam int unsigned DivTidw = 6;

    typedef struct packed {
        logic n;
        logic z;
        logic v;
        logic c;
    } alu_flag_type;

    typedef enum logic [1:0] {c_MUL, c_SMUL, c_UDIV, c_SDIV} mul_ctrl_type;

    typedef enum logic [1:0] {StIdle, StRun, StDone} div_state_type;

    typedef struct packed {
        logic [DivTidw-1:0] tid;
        logic               sgn;
        logic [DivDw-1:0]   y;
        logic [DivDw-1:0]   op1;
        logic [DivDw-1:0]   op2;
    } div_in_type;

    typedef struct packed {
        logic [DivTidw-1:0] tid;
        logic [DivDw-1:0]   result;
        alu_flag_type       flag;
        logic               divz;
    } div_out_type;

    // c_SDIV drives in_signed; every other divide mode is unsigned.
    function automatic logic div_is_signed(input mul_ctrl_type ctrl);
        return ctrl == c_SDIV;
    endfunction

endpackage

// File: rtl/iu_div_step.sv
// Combinational restoring-division step retiring BPC quotient bits, MSB first.
module iu_div_step #(
    parameter int unsigned DW  = 32,
    parameter int unsigned BPC = 1
) (
    input  logic [DW-1:0]  rem_i,
    input  logic [BPC-1:0] bits_i,
    input  logic [DW-1:0]  dvs_i,
    output logic [DW-1:0]  rem_o,
    output logic [BPC-1:0] q_o
);

    logic [DW:0]   trial;
    logic [DW-1:0] rem;

    always_comb begin
        trial = '0;
        rem   = rem_i;
        q_o   = '0;
        for (int i = BPC - 1; i >= 0; i--) begin
            trial = {rem, bits_i[i]};
            if (trial >= {1'b0, dvs_i}) begin
                trial  = trial - {1'b0, dvs_i};
                q_o[i] = 1'b1;
            end
            rem = trial[DW-1:0];
        end
        rem_o = rem;
    end

endmodule

// File: rtl/iu_div_seq.sv
// Sequential SPARC V8 UDIV/SDIV unit: {Y,op1} / op2, BPC bits per cycle, with handshake and kill.
// Optional IU_DIV_FASTZERO_EN: finish in one cycle when |dividend| < |divisor|.
module iu_div_seq
    import libiu::*;
#(
    parameter int unsigned DW   = 32,
    parameter int unsigned BPC  = 1,
    parameter int unsigned TIDW = 6
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [TIDW-1:0] in_tid,
    input  logic            in_signed,
    input  logic [DW-1:0]   in_y,
    input  logic [DW-1:0]   in_op1,
    input  logic [DW-1:0]   in_op2,
    input  logic            kill,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [TIDW-1:0] out_tid,
    output logic [DW-1:0]   out_result,
    output logic [3:0]      out_flag,
    output logic            out_divz
);

    localparam int unsigned NIter = DW / BPC;
    localparam int unsigned CntW  = $clog2(NIter);
    localparam logic [DW-1:0] MinNeg = {1'b1, {(DW-1){1'b0}}};
    localparam logic [DW-1:0] MaxPos = {1'b0, {(DW-1){1'b1}}};

    div_state_type  state_q;
    logic           in_ready_q;
    logic           out_valid_q;
    logic [TIDW-1:0] out_tid_q;
    logic [DW-1:0]  out_result_q;
    alu_flag_type   out_flag_q;
    logic           out_divz_q;

    logic           mode_q;
    logic           neg_q;
    logic           ovf_q;
    logic [DW-1:0]  rem_q;
    logic [DW-1:0]  lo_q;
    logic [DW-1:0]  dvs_q;
    logic [CntW-1:0] cnt_q;

    logic            y_neg;
    logic            d_neg;
    logic [2*DW-1:0] dvd_raw;
    logic [2*DW-1:0] dvd_mag;
    logic [DW-1:0]   dvs_mag;
    logic            pre_ovf;

    logic [DW-1:0]  step_rem;
    logic [BPC-1:0] step_q;
    logic [DW-1:0]  lo_d;
    logic [DW-1:0]  res_pp;
    logic           v_pp;

    always_comb begin
        y_neg   = in_signed & in_y[DW-1];
        d_neg   = in_signed & in_op2[DW-1];
        dvd_raw = {in_y, in_op1};
        dvd_mag = y_neg ? -dvd_raw : dvd_raw;
        dvs_mag = d_neg ? -in_op2 : in_op2;
        pre_ovf = dvd_mag[2*DW-1:DW] >= dvs_mag;
    end

`ifdef IU_DIV_FASTZERO_EN
    logic fast_zero;
    assign fast_zero = (dvd_mag[2*DW-1:DW] == '0) && (dvd_mag[DW-1:0] < dvs_mag);
`endif

    iu_div_step #(
        .DW  (DW),
        .BPC (BPC)
    ) u_step (
        .rem_i  (rem_q),
        .bits_i (lo_q[DW-1 -: BPC]),
        .dvs_i  (dvs_q),
        .rem_o  (step_rem),
        .q_o    (step_q)
    );

    // Quotient bits shift into the bottom of lo_q as dividend bits leave the top.
    assign lo_d = {lo_q[DW-BPC-1:0], step_q};

    always_comb begin
        res_pp = lo_d;
        v_pp   = 1'b0;
        if (!mode_q) begin
            if (ovf_q) begin
                res_pp = '1;
                v_pp   = 1'b1;
            end
        end else if (!neg_q) begin
            if (ovf_q || lo_d[DW-1]) begin
                res_pp = MaxPos;
                v_pp   = 1'b1;
            end
        end else if (ovf_q || (lo_d > MinNeg)) begin
            res_pp = MinNeg;
            v_pp   = 1'b1;
        end else begin
            res_pp = -lo_d;
        end
    end

    function automatic alu_flag_type mk_flag(input logic [DW-1:0] r, input logic v);
        alu_flag_type f;
        f.n = r[DW-1];
        f.z = (r == '0);
        f.v = v;
        f.c = 1'b0;
        return f;
    endfunction

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q      <= StIdle;
            in_ready_q   <= 1'b1;
            out_valid_q  <= 1'b0;
            out_tid_q    <= '0;
            out_result_q <= '0;
            out_flag_q   <= '0;
            out_divz_q   <= 1'b0;
            mode_q       <= 1'b0;
            neg_q        <= 1'b0;
            ovf_q        <= 1'b0;
            rem_q        <= '0;
            lo_q         <= '0;
            dvs_q        <= '0;
            cnt_q        <= '0;
        end else if (kill) begin
            state_q     <= StIdle;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (in_valid) begin
                        out_tid_q <= in_tid;
                        mode_q    <= in_signed;
                        neg_q     <= y_neg ^ d_neg;
                        ovf_q     <= pre_ovf;
                        rem_q     <= dvd_mag[2*DW-1:DW];
                        lo_q      <= dvd_mag[DW-1:0];
                        dvs_q     <= dvs_mag;
                        cnt_q     <= CntW'(NIter - 1);
                        in_ready_q <= 1'b0;
                        if (in_op2 == '0) begin
                            state_q      <= StDone;
                            out_valid_q  <= 1'b1;
                            out_divz_q   <= 1'b1;
                            out_result_q <= '0;
                            out_flag_q   <= '0;
                        end
`ifdef IU_DIV_FASTZERO_EN
                        else if (fast_zero) begin
                            state_q      <= StDone;
                            out_valid_q  <= 1'b1;
                            out_divz_q   <= 1'b0;
                            out_result_q <= '0;
                            out_flag_q   <= mk_flag('0, 1'b0);
                        end
`endif
                        else begin
                            state_q <= StRun;
                        end
                    end
                end
                StRun: begin
                    rem_q <= step_rem;
                    lo_q  <= lo_d;
                    cnt_q <= cnt_q - CntW'(1);
                    if (cnt_q == '0) begin
                        state_q      <= StDone;
                        out_valid_q  <= 1'b1;
                        out_divz_q   <= 1'b0;
                        out_result_q <= res_pp;
                        out_flag_q   <= mk_flag(res_pp, v_pp);
                    end
                end
                StDone: begin
                    if (out_ready) begin
                        state_q     <= StIdle;
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q     <= StIdle;
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                end
            endcase
        end
    end

    assign in_ready   = in_ready_q;
    assign out_valid  = out_valid_q;
    assign out_tid    = out_tid_q;
    assign out_result = out_result_q;
    assign out_flag   = out_flag_q;
    assign out_divz   = out_divz_q;

endmodule
